// File: rtl/attack_turn_ctrl.sv
// Attack-phase game flow: edge-qualified fire/start, shot bookkeeping,
// hit/shot counters, registered win/lose decision and hit/miss feedback.
module attack_turn_ctrl #(
  parameter int N_COLS    = 5,
  parameter int N_LINES   = 7,
  parameter int MAX_SHOTS = 20
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        start,
  input  logic                        confirm,
  input  logic [2:0]                  col,
  input  logic [2:0]                  lin,
  input  logic                        hit_in,
  input  logic [5:0]                  ship_cells,
  output logic [N_COLS*N_LINES-1:0]   attack_map,
  output logic [5:0]                  hits,
  output logic [5:0]                  shots_left,
  output logic [1:0]                  status,
  output logic                        shot_pulse,
  output logic                        reject_pulse,
  output logic                        rgb_r,
  output logic                        rgb_g
);

  localparam int N_CELLS = N_COLS * N_LINES;
  localparam logic [5:0] MAX_HITS   = 6'(N_CELLS);
  localparam logic [5:0] SHOT_GRANT = 6'(MAX_SHOTS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ATTACK = 2'b01,
    ST_WIN    = 2'b10,
    ST_LOSE   = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [N_CELLS-1:0] map_q, map_d;
  logic [5:0]         hits_q, hits_d;
  logic [5:0]         left_q, left_d;
  logic [5:0]         ship_q, ship_d;
  logic               shot_q, shot_d;
  logic               rej_q, rej_d;
  logic               rgb_r_q, rgb_r_d;
  logic               rgb_g_q, rgb_g_d;
  logic               conf_q, start_q;

  logic       fire, go, in_range;
  logic [5:0] idx;

  assign fire     = confirm & ~conf_q;
  assign go       = start & ~start_q;
  assign in_range = (int'(col) < N_COLS) && (int'(lin) < N_LINES);
  assign idx      = 6'(int'(lin) * N_COLS + int'(col));

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    hits_d  = hits_q;
    left_d  = left_q;
    ship_d  = ship_q;
    shot_d  = 1'b0;
    rej_d   = 1'b0;
    rgb_r_d = rgb_r_q;
    rgb_g_d = rgb_g_q;
    if (go) begin
      state_d = ST_ATTACK;
      map_d   = '0;
      hits_d  = '0;
      left_d  = SHOT_GRANT;
      ship_d  = ship_cells;
      rgb_r_d = 1'b0;
      rgb_g_d = 1'b0;
    end else if (state_q == ST_ATTACK) begin
      // Decision looks at the counters as they stood before this edge.
      if (hits_q == ship_q)
        state_d = ST_WIN;
      else if (left_q == '0)
        state_d = ST_LOSE;
      if (fire) begin
        if (!in_range || map_q[idx]) begin
          rej_d = 1'b1;
        end else if (left_q != '0) begin
          map_d[idx] = 1'b1;
          left_d     = left_q - 6'd1;
          shot_d     = 1'b1;
          rgb_r_d    = hit_in;
          rgb_g_d    = ~hit_in;
          if (hit_in && hits_q != MAX_HITS)
            hits_d = hits_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      map_q   <= '0;
      hits_q  <= '0;
      left_q  <= '0;
      ship_q  <= '0;
      shot_q  <= 1'b0;
      rej_q   <= 1'b0;
      rgb_r_q <= 1'b0;
      rgb_g_q <= 1'b0;
      conf_q  <= 1'b1;
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      hits_q  <= hits_d;
      left_q  <= left_d;
      ship_q  <= ship_d;
      shot_q  <= shot_d;
      rej_q   <= rej_d;
      rgb_r_q <= rgb_r_d;
      rgb_g_q <= rgb_g_d;
      conf_q  <= confirm;
      start_q <= start;
    end
  end

  assign attack_map   = map_q;
  assign hits         = hits_q;
  assign shots_left   = left_q;
  assign status       = state_q;
  assign shot_pulse   = shot_q;
  assign reject_pulse = rej_q;
  assign rgb_r        = rgb_r_q;
  assign rgb_g        = rgb_g_q;

endmodule

// File: tb/tb_attack_turn_ctrl.sv
// Bench for attack_turn_ctrl: directed scenarios plus randomized play checked
// against a shot-log reference model.
module tb_attack_turn_ctrl;

  logic        clk = 1'b0;
  logic        clr, start, confirm, hit_in;
  logic [2:0]  col, lin;
  logic [5:0]  ship_cells;
  logic [34:0] attack_map;
  logic [5:0]  hits, shots_left;
  logic [1:0]  status;
  logic        shot_pulse, reject_pulse, rgb_r, rgb_g;

  int n_vec = 0;
  int n_err = 0;

  attack_turn_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .confirm(confirm),
    .col(col), .lin(lin), .hit_in(hit_in), .ship_cells(ship_cells),
    .attack_map(attack_map), .hits(hits), .shots_left(shots_left),
    .status(status), .shot_pulse(shot_pulse), .reject_pulse(reject_pulse),
    .rgb_r(rgb_r), .rgb_g(rgb_g)
  );

  always #5 clk = ~clk;

  // Reference model: a game is the ordered log of accepted shots; every
  // output is derived from that log.
  typedef struct { int idx; bit hit; } shot_t;
  shot_t m_log[$];
  bit    m_conf, m_start, m_fresh, m_shot, m_rej;
  int    m_status, m_ship;

  function automatic int f_hits();
    int h = 0;
    foreach (m_log[i]) if (m_log[i].hit) h++;
    return (h > 35) ? 35 : h;
  endfunction

  function automatic int f_left();
    return m_fresh ? 0 : 20 - m_log.size();
  endfunction

  function automatic logic [34:0] f_map();
    logic [34:0] m = '0;
    foreach (m_log[i]) m[m_log[i].idx] = 1'b1;
    return m;
  endfunction

  function automatic bit f_fired(input int idx);
    foreach (m_log[i]) if (m_log[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit f_r();
    return (m_log.size() > 0) && m_log[m_log.size()-1].hit;
  endfunction

  function automatic bit f_g();
    return (m_log.size() > 0) && !m_log[m_log.size()-1].hit;
  endfunction

  task automatic model_edge();
    bit fire, go;
    int nxt;
    if (clr) begin
      m_conf = 1; m_start = 1; m_status = 0; m_ship = 0; m_fresh = 1;
      m_shot = 0; m_rej = 0; m_log.delete();
      return;
    end
    fire = confirm && !m_conf;
    go   = start && !m_start;
    m_conf = confirm; m_start = start;
    m_shot = 0; m_rej = 0;
    if (go) begin
      m_log.delete(); m_ship = int'(ship_cells); m_fresh = 0; m_status = 1;
    end else if (m_status == 1) begin
      nxt = (f_hits() == m_ship) ? 2 : (f_left() == 0) ? 3 : 1;
      if (fire) begin
        if (col >= 5 || lin >= 7) m_rej = 1;
        else if (f_fired(int'(lin) * 5 + int'(col))) m_rej = 1;
        else if (f_left() > 0) begin
          m_log.push_back('{idx: int'(lin) * 5 + int'(col), hit: hit_in});
          m_shot = 1;
        end
      end
      m_status = nxt;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1; confirm = 1; start = 0; col = 0; lin = 0; hit_in = 0; ship_cells = 0;
    repeat (3) tick();
    clr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (status !== 2'b00) begin n_err++; $display("FAIL reset_status got %b want 00", status); end
      n_vec++; if (shot_pulse !== 1'b0 || reject_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulses got %b%b want 00", shot_pulse, reject_pulse); end
      n_vec++; if (attack_map !== 35'd0 || hits !== 6'd0 || shots_left !== 6'd0) begin n_err++; $display("FAIL reset_counters got map=%h hits=%0d left=%0d want 0", attack_map, hits, shots_left); end
      n_vec++; if (rgb_r !== 1'b0 || rgb_g !== 1'b0) begin n_err++; $display("FAIL reset_rgb got %b%b want 00", rgb_r, rgb_g); end
    end
    confirm = 0; tick();
  endtask

  task automatic test_start();
    ship_cells = 2; start = 1; tick();
    n_vec++; if (status !== 2'b01) begin n_err++; $display("FAIL start_status got %b want 01", status); end
    n_vec++; if (shots_left !== 6'd20 || hits !== 6'd0 || attack_map !== 35'd0) begin n_err++; $display("FAIL start_init got left=%0d hits=%0d map=%h want 20 0 0", shots_left, hits, attack_map); end
    start = 0; tick();
  endtask

  task automatic test_hit_and_reject();
    col = 1; lin = 2; hit_in = 1; confirm = 1; tick();
    n_vec++; if (attack_map !== 35'h800 || hits !== 6'd1 || shots_left !== 6'd19) begin n_err++; $display("FAIL hit_counters got map=%h hits=%0d left=%0d want 800 1 19", attack_map, hits, shots_left); end
    n_vec++; if (shot_pulse !== 1'b1 || rgb_r !== 1'b1 || rgb_g !== 1'b0) begin n_err++; $display("FAIL hit_flags got shot=%b r=%b g=%b want 1 1 0", shot_pulse, rgb_r, rgb_g); end
    tick();
    n_vec++; if (shot_pulse !== 1'b0) begin n_err++; $display("FAIL held_confirm got shot=%b want 0", shot_pulse); end
    confirm = 0; tick();
    confirm = 1; tick();
    n_vec++; if (reject_pulse !== 1'b1 || shot_pulse !== 1'b0 || hits !== 6'd1 || shots_left !== 6'd19) begin n_err++; $display("FAIL repeat got rej=%b shot=%b hits=%0d left=%0d want 1 0 1 19", reject_pulse, shot_pulse, hits, shots_left); end
    confirm = 0; tick();
    n_vec++; if (reject_pulse !== 1'b0) begin n_err++; $display("FAIL rej_width got %b want 0", reject_pulse); end
    col = 5; lin = 0; confirm = 1; tick();
    n_vec++; if (reject_pulse !== 1'b1 || attack_map !== 35'h800 || shots_left !== 6'd19) begin n_err++; $display("FAIL out_of_range got rej=%b map=%h left=%0d want 1 800 19", reject_pulse, attack_map, shots_left); end
    confirm = 0; tick();
  endtask

  task automatic test_win();
    col = 3; lin = 4; hit_in = 1; confirm = 1; tick();
    n_vec++; if (hits !== 6'd2 || status !== 2'b01) begin n_err++; $display("FAIL win_hit got hits=%0d status=%b want 2 01", hits, status); end
    confirm = 0; tick();
    n_vec++; if (status !== 2'b10) begin n_err++; $display("FAIL win_status got %b want 10", status); end
    col = 0; lin = 0; hit_in = 0; confirm = 1; tick();
    n_vec++; if (status !== 2'b10 || shot_pulse !== 1'b0 || reject_pulse !== 1'b0 || shots_left !== 6'd18) begin n_err++; $display("FAIL win_frozen got status=%b shot=%b rej=%b left=%0d want 10 0 0 18", status, shot_pulse, reject_pulse, shots_left); end
    confirm = 0; tick();
  endtask

  task automatic test_lose();
    ship_cells = 2; start = 1; tick(); start = 0; tick();
    for (int i = 0; i < 20; i++) begin
      col = 3'(i % 5); lin = 3'(i / 5); hit_in = 0; confirm = 1; tick();
      confirm = 0;
      if (i == 19) begin
        n_vec++; if (shots_left !== 6'd0 || rgb_g !== 1'b1 || rgb_r !== 1'b0 || status !== 2'b01) begin n_err++; $display("FAIL last_miss got left=%0d g=%b r=%b status=%b want 0 1 0 01", shots_left, rgb_g, rgb_r, status); end
      end
      tick();
    end
    n_vec++; if (status !== 2'b11 || shots_left !== 6'd0) begin n_err++; $display("FAIL lose_status got %b left=%0d want 11 0", status, shots_left); end
  endtask

  task automatic test_zero_ships();
    ship_cells = 0; start = 1; tick();
    n_vec++; if (status !== 2'b01) begin n_err++; $display("FAIL zero_init got %b want 01", status); end
    start = 0; tick();
    n_vec++; if (status !== 2'b10) begin n_err++; $display("FAIL zero_win got %b want 10", status); end
  endtask

  task automatic test_start_fire_same();
    ship_cells = 3; col = 0; lin = 0; hit_in = 1; start = 1; confirm = 1; tick();
    n_vec++; if (status !== 2'b01 || shot_pulse !== 1'b0 || reject_pulse !== 1'b0) begin n_err++; $display("FAIL same_edge_flags got status=%b shot=%b rej=%b want 01 0 0", status, shot_pulse, reject_pulse); end
    n_vec++; if (shots_left !== 6'd20 || hits !== 6'd0 || attack_map !== 35'd0) begin n_err++; $display("FAIL same_edge_counts got left=%0d hits=%0d map=%h want 20 0 0", shots_left, hits, attack_map); end
    start = 0; confirm = 0; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clr        = ($urandom_range(0, 249) == 0);
      start      = ($urandom_range(0, 29) == 0);
      confirm    = 1'($urandom_range(0, 1));
      col        = 3'($urandom_range(0, 5));
      lin        = 3'($urandom_range(0, 7));
      hit_in     = ($urandom_range(0, 2) == 0);
      ship_cells = 6'($urandom_range(0, 5));
      tick();
      n_vec++; if (status !== 2'(m_status)) begin n_err++; $display("FAIL rnd_status cyc %0d got %b want %0d", i, status, m_status); end
      n_vec++; if (attack_map !== f_map()) begin n_err++; $display("FAIL rnd_map cyc %0d got %h want %h", i, attack_map, f_map()); end
      n_vec++; if (hits !== 6'(f_hits()) || shots_left !== 6'(f_left())) begin n_err++; $display("FAIL rnd_counts cyc %0d got hits=%0d left=%0d want %0d %0d", i, hits, shots_left, f_hits(), f_left()); end
      n_vec++; if (shot_pulse !== m_shot || reject_pulse !== m_rej) begin n_err++; $display("FAIL rnd_pulses cyc %0d got %b%b want %b%b", i, shot_pulse, reject_pulse, m_shot, m_rej); end
      n_vec++; if (rgb_r !== f_r() || rgb_g !== f_g()) begin n_err++; $display("FAIL rnd_rgb cyc %0d got %b%b want %b%b", i, rgb_r, rgb_g, f_r(), f_g()); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_and_reject();
    test_win();
    test_lose();
    test_zero_ships();
    test_start_fire_same();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/attack_turn_ctrl.md
Name: attack_turn_ctrl

Overview:
- Game-flow controller for the attack phase of the battleship board. It sits upstream of the attack-matrix/LED stage.
- Consumes the debounced confirm button, the 3-bit column/line coordinate and the hit bit read from the position matrix at that coordinate.
- Produces the 35-bit attacked-cell map, hit/shot counters, game status and RGB hit/miss feedback.
- Replaces the purely combinational confirm/at_confirm path with registered, edge-qualified shot logic.

Parameters:
N_COLS, 5, board columns (col valid 0..N_COLS-1)
N_LINES, 7, board lines (lin valid 0..N_LINES-1)
MAX_SHOTS, 20, shots granted per game (1..63)

Ports:
clk  in  1  system clock (divided clock domain of matrix scan)
clr  in  1  synchronous active-high reset
start  in  1  debounced level; rising edge starts/restarts a game
confirm  in  1  debounced level, active-high; rising edge = fire
col  in  3  target column, 0-based
lin  in  3  target line, 0-based
hit_in  in  1  position-matrix bit at (col,lin), combinational, valid whenever col/lin stable
ship_cells  in  6  number of occupied cells in loaded preset; sampled at start edge
attack_map  out  35  bit (lin*5+col) set once that cell has been fired on
hits  out  6  hits scored this game
shots_left  out  6  remaining shots
status  out  2  00 IDLE, 01 ATTACK, 10 WIN, 11 LOSE
shot_pulse  out  1  one-cycle pulse when a shot is accepted
reject_pulse  out  1  one-cycle pulse when a fire edge is refused (out of range or repeat)
rgb_r  out  1  latched: last accepted shot was a hit
rgb_g  out  1  latched: last accepted shot was a miss

Behaviour:
- Edge detect: conf_q <= confirm and start_q <= start every cycle. fire = confirm & ~conf_q; go = start & ~start_q. Both registers reset to 1, so a button held through clr produces no edge.
- Reset (clr=1 at clk edge), overriding everything:
  - status=IDLE, attack_map=0, hits=0, shots_left=0, ship_reg=0.
  - shot_pulse=0, reject_pulse=0, rgb_r=0, rgb_g=0.
- States:
  - IDLE: fire ignored (no reject_pulse). go -> ATTACK with init.
  - ATTACK: shots processed as below. go -> re-init while staying in ATTACK. Win/lose check as below.
  - WIN / LOSE: terminal, outputs frozen, fire ignored. go -> ATTACK with init.
- Init (same edge as go): attack_map=0, hits=0, shots_left=MAX_SHOTS, ship_reg=ship_cells, rgb_r=rgb_g=0. go has priority over a simultaneous fire: the fire is dropped.
- Shot, when in ATTACK, fire=1 and go=0, evaluated at that edge, results visible next cycle:
  - col>=N_COLS or lin>=N_LINES -> reject_pulse=1, nothing else changes.
  - attack_map[idx]=1 (repeat) -> reject_pulse=1, no shot consumed.
  - otherwise: attack_map[idx]<=1, shots_left<=shots_left-1, shot_pulse=1. If hit_in: hits<=hits+1, rgb_r=1, rgb_g=0; else rgb_r=0, rgb_g=1.
  - idx = lin*N_COLS + col (6-bit).
- Win/lose check, registered, one cycle after the counters update, so status changes 2 cycles after the fire edge:
  - in ATTACK: hits==ship_reg -> WIN; else shots_left==0 -> LOSE.
  - WIN has priority when the last shot is also the winning hit.
  - ship_reg==0 -> WIN on the cycle after init.
- Counters saturate: shots_left never decrements below 0 (no fire is accepted at 0 since the state has already left ATTACK); hits never exceeds 35.
- shot_pulse and reject_pulse are mutually exclusive and each lasts exactly one cycle.
- A confirm held high produces exactly one shot.

Test Plan:
- clr with confirm=1 held, then release clr -> all outputs 0, status=00, no shot_pulse while confirm stays high.
- start edge with ship_cells=2, MAX_SHOTS=20 -> status=01, shots_left=20, hits=0, attack_map=0.
- Fire col=1 lin=2 hit_in=1 -> next cycle attack_map[11]=1, hits=1, shots_left=19, shot_pulse=1, rgb_r=1.
- Fire again at the same cell -> reject_pulse=1, counters unchanged.
- Fire col=5 lin=0 -> reject_pulse=1, attack_map unchanged.
- Second distinct hit -> hits=2; two cycles after the fire edge status=10, further fires ignored.
- Restart, then 20 misses -> rgb_g=1, shots_left=0, status=11.
- ship_cells=0 at start -> status=10 one cycle after init.
- start and fire on the same edge -> init only, no shot counted.
